// File: rtl/ofifo_drain.sv
// Output-FIFO drain: waits for a full row, reads it, and writes it to psum SRAM at base+n.
// Latency: one row per RD_LAT+3 cycles (POLL, READ, RD_LAT x WAIT, WRITE); one read outstanding.
// Backpressure: stalls in POLL while ofifo_valid is low; the SRAM port never stalls.
// Optional build macro OFIFO_DRAIN_RELU_EN: clamp negative lanes to zero on capture.
module ofifo_drain #(
   parameter int unsigned col    = 8,
   parameter int unsigned bw     = 4,
   parameter int unsigned ADDR_W = 11,
   parameter int unsigned RD_LAT = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [ADDR_W-1:0]   len,
   input  logic [ADDR_W-1:0]   base_addr,
   output logic                busy,
   output logic                done,
   output logic [ADDR_W-1:0]   wr_cnt,
   input  logic                ofifo_valid,
   output logic                ofifo_rd,
   input  logic [bw*col-1:0]   ofifo_out,
   output logic                sram_cen,
   output logic                sram_wen,
   output logic [ADDR_W-1:0]   sram_addr,
   output logic [bw*col-1:0]   sram_d
);

   typedef enum logic [2:0] {
      S_IDLE, S_POLL, S_READ, S_WAIT, S_WRITE, S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [3:0]          lat_q, lat_d;
   logic [ADDR_W-1:0]   len_q, len_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W-1:0]   cnt_inc;
   logic [bw*col-1:0]   data_q, data_d;
   logic [bw*col-1:0]   row_in;

`ifdef OFIFO_DRAIN_RELU_EN
   // Lane-wise ReLU on the incoming row: a set sign bit zeroes the lane.
   always_comb begin
      row_in = ofifo_out;
      for (int i = 0; i < int'(col); i++) begin
         if (ofifo_out[bw*i + bw - 1]) begin
            row_in[bw*i +: bw] = '0;
         end
      end
   end
`else
   assign row_in = ofifo_out;
`endif

   assign cnt_inc = cnt_q + ADDR_W'(1);

   // Next-state and datapath update; all strobes decode from the registered state.
   always_comb begin
      state_d = state_q;
      lat_d   = lat_q;
      len_d   = len_q;
      base_d  = base_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      data_d  = data_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               len_d   = len;
               base_d  = base_addr;
               cnt_d   = '0;
               state_d = (len == '0) ? S_DONE : S_POLL;
            end
         end
         S_POLL: begin
            if (ofifo_valid) begin
               state_d = S_READ;
            end
         end
         S_READ: begin
            lat_d   = 4'(RD_LAT);
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // The last WAIT cycle is RD_LAT cycles after READ: row data is valid now.
            if (lat_q == 4'd1) begin
               data_d  = row_in;
               addr_d  = base_q + cnt_q;
               state_d = S_WRITE;
            end else begin
               lat_d = lat_q - 4'd1;
            end
         end
         S_WRITE: begin
            cnt_d   = cnt_inc;
            state_d = (cnt_inc == len_q) ? S_DONE : S_POLL;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Job parameters, row counter, latency counter and SRAM address/data registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         lat_q  <= '0;
         len_q  <= '0;
         base_q <= '0;
         cnt_q  <= '0;
         addr_q <= '0;
         data_q <= '0;
      end else begin
         lat_q  <= lat_d;
         len_q  <= len_d;
         base_q <= base_d;
         cnt_q  <= cnt_d;
         addr_q <= addr_d;
         data_q <= data_d;
      end
   end

   assign ofifo_rd  = (state_q == S_READ);
   assign sram_cen  = (state_q != S_WRITE);
   assign sram_wen  = (state_q != S_WRITE);
   assign done      = (state_q == S_DONE);
   assign busy      = (state_q == S_POLL) || (state_q == S_READ) ||
                      (state_q == S_WAIT) || (state_q == S_WRITE);
   assign wr_cnt    = cnt_q;
   assign sram_addr = addr_q;
   assign sram_d    = data_q;

endmodule

// File: tb/tb_ofifo_drain.sv
// Directed bench for ofifo_drain: table of drain jobs plus hand-written corner sequences.
// A behavioural FIFO presents each row exactly RD_LAT cycles after its read pulse.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_ofifo_drain;
   localparam int AW  = 11;
   localparam int W   = 32;
   localparam int RDL = 2;
   localparam logic [W-1:0] GARB = 32'hDEAD_BEEF;

   logic          clk = 1'b0;
   logic          reset, start, ofifo_valid;
   logic [AW-1:0] len, base_addr;
   logic          busy, done, ofifo_rd, sram_cen, sram_wen;
   logic [AW-1:0] wr_cnt, sram_addr;
   logic [W-1:0]  ofifo_out, sram_d;

   ofifo_drain #(.col(8), .bw(4), .ADDR_W(AW), .RD_LAT(RDL)) dut (
      .clk(clk), .reset(reset), .start(start), .len(len), .base_addr(base_addr),
      .busy(busy), .done(done), .wr_cnt(wr_cnt),
      .ofifo_valid(ofifo_valid), .ofifo_rd(ofifo_rd), .ofifo_out(ofifo_out),
      .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_d(sram_d)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int            n_vec = 0;
   int            n_bad = 0;
   int            rd_cyc[$];
   int            wr_cyc[$];
   logic [AW-1:0] wr_addr[$];
   logic [W-1:0]  wr_dat[$];
   int            pend[$];
   logic [W-1:0]  rows[$];
   int            done_cnt = 0;

   // FIFO model and bus monitor.
   always @(negedge clk) begin
      if (pend.size() > 0 && pend[0] == cyc) begin
         void'(pend.pop_front());
         if (rows.size() > 0) ofifo_out = rows.pop_front();
         else                 ofifo_out = GARB;
      end else begin
         ofifo_out = GARB;
      end
      if (ofifo_rd === 1'b1) begin
         rd_cyc.push_back(cyc);
         pend.push_back(cyc + RDL);
      end
      if (sram_cen === 1'b0 && sram_wen === 1'b0) begin
         wr_cyc.push_back(cyc);
         wr_addr.push_back(sram_addr);
         wr_dat.push_back(sram_d);
      end
      if (done === 1'b1) done_cnt++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_logs();
      rd_cyc.delete(); wr_cyc.delete(); wr_addr.delete(); wr_dat.delete();
      pend.delete(); rows.delete();
      done_cnt = 0;
   endtask

   task automatic start_job(input logic [AW-1:0] b, input logic [AW-1:0] l, output int s_cyc);
      @(posedge clk); #1;
      start = 1'b1; base_addr = b; len = l; s_cyc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      bit ok = 1'b0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (done === 1'b1) begin ok = 1'b1; break; end
      end
      chk({name, "_done_seen"}, 32'(ok), 32'd1);
      repeat (3) @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [AW-1:0] base;
      logic [AW-1:0] len;
      logic [W-1:0]  row[4];
      logic [AW-1:0] exp_addr[4];
      logic [W-1:0]  exp_dat[4];
      bit            mid_start;
   } vec_t;

   vec_t vt[3];

`ifdef OFIFO_DRAIN_RELU_EN
   localparam logic [W-1:0] SIGNED_ROW_EXP = 32'h0000_1070;
`else
   localparam logic [W-1:0] SIGNED_ROW_EXP = 32'h0000_1F78;
`endif

   initial begin
      int s, v, stray, nrd;
      vt[0] = '{base: 11'd5, len: 11'd3,
                row: '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h0},
                exp_addr: '{11'd5, 11'd6, 11'd7, 11'd0},
                exp_dat: '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h0},
                mid_start: 1'b0};
      vt[1] = '{base: 11'd2046, len: 11'd4,
                row: '{32'h4444_4444, 32'h0000_1F78, 32'h5555_5555, 32'h6666_6666},
                exp_addr: '{11'd2046, 11'd2047, 11'd0, 11'd1},
                exp_dat: '{32'h4444_4444, SIGNED_ROW_EXP, 32'h5555_5555, 32'h6666_6666},
                mid_start: 1'b1};
      vt[2] = '{base: 11'd0, len: 11'd1,
                row: '{32'h1234_5670, 32'h0, 32'h0, 32'h0},
                exp_addr: '{11'd0, 11'd0, 11'd0, 11'd0},
                exp_dat: '{32'h1234_5670, 32'h0, 32'h0, 32'h0},
                mid_start: 1'b0};

      reset = 1'b1; start = 1'b0; len = '0; base_addr = '0; ofifo_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_rd",   32'(ofifo_rd),  32'd0);
      chk("rst_cen",  32'(sram_cen),  32'd1);
      chk("rst_wen",  32'(sram_wen),  32'd1);
      chk("rst_addr", 32'(sram_addr), 32'd0);
      chk("rst_d",    sram_d,         32'd0);
      chk("rst_busy", 32'(busy),      32'd0);
      chk("rst_done", 32'(done),      32'd0);
      chk("rst_cnt",  32'(wr_cnt),    32'd0);
      @(posedge clk); #1 reset = 1'b0;

      // Table of drain jobs with the FIFO always ready.
      for (int i = 0; i < 3; i++) begin
         clear_logs();
         for (int r = 0; r < int'(vt[i].len); r++) rows.push_back(vt[i].row[r]);
         ofifo_valid = 1'b1;
         start_job(vt[i].base, vt[i].len, s);
         if (vt[i].mid_start) begin
            repeat (6) @(posedge clk);
            #1 chk("mid_busy", 32'(busy), 32'd1);
            start_job(11'd100, 11'd1, v);
         end
         wait_done($sformatf("v%0d", i));
         chk($sformatf("v%0d_rd_count", i), 32'(rd_cyc.size()), 32'(vt[i].len));
         if (rd_cyc.size() > 0) begin
            chk($sformatf("v%0d_first_rd", i), 32'(rd_cyc[0] - s), 32'd2);
            if (wr_cyc.size() > 0)
               chk($sformatf("v%0d_wr_lat", i), 32'(wr_cyc[0] - rd_cyc[0]), 32'(RDL + 1));
         end
         for (int k = 1; k < rd_cyc.size(); k++)
            chk($sformatf("v%0d_rd_gap%0d", i, k), 32'(rd_cyc[k] - rd_cyc[k-1]), 32'(RDL + 3));
         chk($sformatf("v%0d_wr_count", i), 32'(wr_addr.size()), 32'(vt[i].len));
         for (int k = 0; k < int'(vt[i].len) && k < wr_addr.size(); k++) begin
            chk($sformatf("v%0d_addr%0d", i, k), 32'(wr_addr[k]), 32'(vt[i].exp_addr[k]));
            chk($sformatf("v%0d_data%0d", i, k), wr_dat[k], vt[i].exp_dat[k]);
         end
         chk($sformatf("v%0d_done_cnt", i), 32'(done_cnt), 32'd1);
         chk($sformatf("v%0d_wr_cnt", i), 32'(wr_cnt), 32'(vt[i].len));
         chk($sformatf("v%0d_busy_after", i), 32'(busy), 32'd0);
      end

      // Zero-length job: immediate done, nothing else, counter cleared.
      clear_logs();
      start_job(11'd50, 11'd0, s);
      repeat (4) @(posedge clk);
      #1;
      chk("zero_done_cnt", 32'(done_cnt), 32'd1);
      chk("zero_rd",       32'(rd_cyc.size()), 32'd0);
      chk("zero_wr",       32'(wr_addr.size()), 32'd0);
      chk("zero_wr_cnt",   32'(wr_cnt), 32'd0);

      // Stall in POLL until the FIFO reports a full row.
      clear_logs();
      ofifo_valid = 1'b0;
      rows.push_back(32'h0123_4567);
      start_job(11'd10, 11'd1, s);
      stray = 0;
      repeat (20) begin
         @(negedge clk);
         if (ofifo_rd !== 1'b0 || sram_cen !== 1'b1) stray++;
      end
      chk("stall_strobes", 32'(stray), 32'd0);
      chk("stall_busy", 32'(busy), 32'd1);
      @(posedge clk); #1;
      ofifo_valid = 1'b1; v = cyc;
      wait_done("stall");
      chk("stall_rd_count", 32'(rd_cyc.size()), 32'd1);
      if (rd_cyc.size() > 0) chk("stall_first_rd", 32'(rd_cyc[0] - v), 32'd1);
      chk("stall_wr_count", 32'(wr_addr.size()), 32'd1);
      if (wr_addr.size() > 0) begin
         chk("stall_addr", 32'(wr_addr[0]), 32'd10);
         chk("stall_data", wr_dat[0], 32'h0123_4567);
      end

      // Reset during WAIT of row 1.
      clear_logs();
      ofifo_valid = 1'b1;
      rows.push_back(32'h7777_7777); rows.push_back(32'h1212_1212); rows.push_back(32'h3434_3434);
      start_job(11'd20, 11'd3, s);
      nrd = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (ofifo_rd === 1'b1) begin
            nrd++;
            if (nrd == 2) break;
         end
      end
      chk("rstmid_reads_seen", 32'(nrd), 32'd2);
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rstmid_rd",   32'(ofifo_rd),  32'd0);
      chk("rstmid_cen",  32'(sram_cen),  32'd1);
      chk("rstmid_wen",  32'(sram_wen),  32'd1);
      chk("rstmid_addr", 32'(sram_addr), 32'd0);
      chk("rstmid_d",    sram_d,         32'd0);
      chk("rstmid_busy", 32'(busy),      32'd0);
      chk("rstmid_cnt",  32'(wr_cnt),    32'd0);
      @(posedge clk); #1 reset = 1'b0;
      repeat (10) @(posedge clk);
      #1 chk("rstmid_writes", 32'(wr_addr.size()), 32'd1);

      clear_logs();
      rows.push_back(32'h5656_5656);
      start_job(11'd30, 11'd1, s);
      wait_done("post_rst");
      chk("post_rst_wr_count", 32'(wr_addr.size()), 32'd1);
      if (wr_addr.size() > 0) begin
         chk("post_rst_addr", 32'(wr_addr[0]), 32'd30);
         chk("post_rst_data", wr_dat[0], 32'h5656_5656);
      end
      chk("post_rst_wr_cnt", 32'(wr_cnt), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1);
   end
endmodule
